// File: rtl/seg_scan_if.sv
// Signal bundle between a digit source and the multiplexed 7-segment scan driver.
// master drives the digit patterns and controls; slave is the scan driver.
interface seg_scan_if;
    logic [6:0] seg_in0;
    logic [6:0] seg_in1;
    logic [6:0] seg_in2;
    logic [6:0] seg_in3;
    logic [3:0] blink_mask;
    logic       enable;
    logic [6:0] seg_out;
    logic [3:0] dig_sel;
    logic       frame_start;

    modport master (
        output seg_in0, seg_in1, seg_in2, seg_in3, blink_mask, enable,
        input  seg_out, dig_sel, frame_start
    );

    modport slave (
        input  seg_in0, seg_in1, seg_in2, seg_in3, blink_mask, enable,
        output seg_out, dig_sel, frame_start
    );
endinterface

// File: rtl/seg_scan_driver.sv
// 4-digit multiplexed 7-segment scan driver: per-frame input snapshot,
// anti-ghosting blank at every slot start, and per-digit blinking.
module seg_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int BLINK_TICKS    = 500,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit DIG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        reset_n,
    seg_scan_if.slave   bus
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam int BW = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] BLANK_LIM = PW'(BLANK_CYCLES);
    localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);
    localparam logic [6:0]    SEG_OFF   = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [3:0]    DIG_OFF   = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    idx_q, idx_d;
    logic [BW-1:0] bcnt_q, bcnt_d;
    logic          phase_q, phase_d;
    logic          en_prev_q;
    logic [6:0]    shadow_q [4];
    logic [3:0]    mask_q;
    logic [6:0]    seg_q, seg_d;
    logic [3:0]    dig_q, dig_d;
    logic          fs_q;

    logic [6:0]    seg_in_w [4];
    logic [3:0]    dig_onehot;
    logic [3:0]    eff_mask;
    logic          tick;
    logic          snap;
    logic          blank;

    assign seg_in_w[0] = bus.seg_in0;
    assign seg_in_w[1] = bus.seg_in1;
    assign seg_in_w[2] = bus.seg_in2;
    assign seg_in_w[3] = bus.seg_in3;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_onehot
            assign dig_onehot[gi] = (idx_q == 2'(gi));
        end
    endgenerate

    assign tick = (presc_q == PRESC_MAX);
    // The first enabled clock (after reset or an enable rise) also loads a frame.
    assign snap = bus.enable && (!en_prev_q || (tick && idx_q == 2'd3));
    assign eff_mask = phase_q ? mask_q : 4'h0;

    always_comb begin
        presc_d = presc_q;
        idx_d   = idx_q;
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (!bus.enable) begin
            presc_d = '0;
            idx_d   = '0;
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            presc_d = '0;
            idx_d   = idx_q + 2'd1;
            if (bcnt_q == BLINK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end else begin
            presc_d = presc_q + 1'b1;
        end
    end

    always_comb begin
        blank = (presc_q < BLANK_LIM) || !bus.enable || eff_mask[idx_q];
        seg_d = SEG_OFF;
        dig_d = DIG_OFF;
        if (!blank) begin
            seg_d = SEG_ACTIVE_LOW ? ~shadow_q[idx_q] : shadow_q[idx_q];
            dig_d = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            bcnt_q    <= '0;
            phase_q   <= 1'b0;
            en_prev_q <= 1'b0;
            mask_q    <= '0;
            seg_q     <= SEG_OFF;
            dig_q     <= DIG_OFF;
            fs_q      <= 1'b0;
            for (int i = 0; i < 4; i++) shadow_q[i] <= '0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            bcnt_q    <= bcnt_d;
            phase_q   <= phase_d;
            en_prev_q <= bus.enable;
            seg_q     <= seg_d;
            dig_q     <= dig_d;
            fs_q      <= snap;
            if (snap) begin
                mask_q <= bus.blink_mask;
                for (int i = 0; i < 4; i++) shadow_q[i] <= seg_in_w[i];
            end
        end
    end

    assign bus.seg_out     = seg_q;
    assign bus.dig_sel     = dig_q;
    assign bus.frame_start = fs_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: scan order, snapshot timing, blinking,
// enable drop, asynchronous reset and non-inverted polarity.
module tb_seg_scan_driver;

    logic clk = 1'b0;
    logic reset_n;
    int   checks = 0;
    int   errors = 0;

    seg_scan_if bus_a ();
    seg_scan_if bus_b ();

    seg_scan_driver #(
        .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_TICKS(8),
        .SEG_ACTIVE_LOW(1'b1), .DIG_ACTIVE_LOW(1'b1)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a)
    );

    seg_scan_driver #(
        .REFRESH_DIV(4), .BLANK_CYCLES(1), .BLINK_TICKS(8),
        .SEG_ACTIVE_LOW(1'b0), .DIG_ACTIVE_LOW(1'b0)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .bus(bus_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [6:0] p0, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] p3, input logic [3:0] m, input logic en);
        bus_a.seg_in0 = p0; bus_a.seg_in1 = p1; bus_a.seg_in2 = p2; bus_a.seg_in3 = p3;
        bus_a.blink_mask = m; bus_a.enable = en;
        bus_b.seg_in0 = p0; bus_b.seg_in1 = p1; bus_b.seg_in2 = p2; bus_b.seg_in3 = p3;
        bus_b.blink_mask = m; bus_b.enable = en;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] dig_a, input logic [6:0] seg_a,
                           input logic [3:0] dig_b, input logic [6:0] seg_b, input logic fs);
        chk({tag, " dig_a"}, 32'(bus_a.dig_sel), 32'(dig_a));
        chk({tag, " seg_a"}, 32'(bus_a.seg_out), 32'(seg_a));
        chk({tag, " dig_b"}, 32'(bus_b.dig_sel), 32'(dig_b));
        chk({tag, " seg_b"}, 32'(bus_b.seg_out), 32'(seg_b));
        chk({tag, " fs_a"},  32'(bus_a.frame_start), 32'(fs));
        chk({tag, " fs_b"},  32'(bus_b.frame_start), 32'(fs));
        $display("%s: dig_a=%h seg_a=%h dig_b=%h seg_b=%h fs=%b", tag,
                 bus_a.dig_sel, bus_a.seg_out, bus_b.dig_sel, bus_b.seg_out, bus_a.frame_start);
    endtask

    initial begin
        logic [6:0] old_pat [4];
        logic [6:0] new_pat [4];
        logic [6:0] pat;
        logic [3:0] oh, eff;
        logic       lit, fs;
        int         f, slot, pos;

        old_pat[0] = 7'h06; old_pat[1] = 7'h5B; old_pat[2] = 7'h4F; old_pat[3] = 7'h66;
        new_pat[0] = 7'h3F; new_pat[1] = 7'h5B; new_pat[2] = 7'h4F; new_pat[3] = 7'h7F;

        reset_n = 1'b0;
        drive(7'h06, 7'h5B, 7'h4F, 7'h66, 4'h0, 1'b0);
        repeat (3) @(negedge clk);
        chk_all("reset", 4'hF, 7'h7F, 4'h0, 7'h00, 1'b0);

        reset_n = 1'b1;
        bus_a.enable = 1'b1;
        bus_b.enable = 1'b1;

        // 8 frames: snapshot update in frame 2, blink dark in frames 2,3,6,7.
        for (int k = 0; k < 128; k++) begin
            @(negedge clk);
            f    = k / 16;
            slot = (k % 16) / 4;
            pos  = k % 4;
            pat  = (f >= 2) ? new_pat[slot] : old_pat[slot];
            eff  = (((f / 2) % 2) == 1 && f >= 2) ? 4'b0011 : 4'b0000;
            lit  = (pos != 0) && !eff[slot];
            oh   = 4'b0001 << slot;
            fs   = (k == 0) || ((k % 16) == 15);
            chk_all($sformatf("scan k=%0d", k),
                    lit ? ~oh : 4'hF, lit ? ~pat : 7'h7F,
                    lit ? oh : 4'h0,  lit ? pat : 7'h00, fs);
            if (k == 25) drive(7'h3F, 7'h5B, 7'h4F, 7'h7F, 4'b0011, 1'b1);
        end

        // Drop enable mid-slot for three clocks.
        @(negedge clk);
        @(negedge clk);
        bus_a.enable = 1'b0;
        bus_b.enable = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk_all($sformatf("disabled %0d", j), 4'hF, 7'h7F, 4'h0, 7'h00, 1'b0);
        end
        bus_a.enable = 1'b1;
        bus_b.enable = 1'b1;
        @(negedge clk);
        chk_all("reenable blank", 4'hF, 7'h7F, 4'h0, 7'h00, 1'b1);
        @(negedge clk);
        chk_all("reenable dig0", 4'hE, 7'h40, 4'h1, 7'h3F, 1'b0);
        repeat (3) @(negedge clk);
        chk_all("reenable blank1", 4'hF, 7'h7F, 4'h0, 7'h00, 1'b0);
        @(negedge clk);
        chk_all("reenable dig1", 4'hD, 7'h24, 4'h2, 7'h5B, 1'b0);

        // Asynchronous reset between clock edges.
        #2 reset_n = 1'b0;
        #1 chk_all("async reset", 4'hF, 7'h7F, 4'h0, 7'h00, 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        chk_all("post reset blank", 4'hF, 7'h7F, 4'h0, 7'h00, 1'b1);
        @(negedge clk);
        chk_all("post reset dig0", 4'hE, 7'h40, 4'h1, 7'h3F, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
